// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address,
// byte receive with ACK/NACK and byte transmit with master ACK checking.
module i2c_target #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 7,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h42
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCL_in,
  input  logic                  SDA_in,
  output logic                  SDA_out,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack_en,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_load,
  output logic                  tx_underrun,
  output logic                  addressed,
  output logic                  busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] ACK_SLOT = 4'(DATA_WIDTH);
  localparam logic [3:0] ACK_DONE = 4'(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACKCHK, WAIT_STOP
  } state_e;

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  state_e                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  sda_out_q, sda_out_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_load_q, tx_load_d;
  logic                  tx_underrun_q, tx_underrun_d;
  logic                  addressed_q, addressed_d;
  logic                  busy_q, busy_d;

  logic                  scl_rise_c, scl_fall_c, start_c, stop_c;
  logic [DATA_WIDTH-1:0] shift_in_c, tx_byte_c;
  logic [3:0]            bit_inc_c;

  // Bus conditions; START/STOP require SCL high in both current and previous sample.
  assign scl_rise_c = scl_sync_q & ~scl_hist_q;
  assign scl_fall_c = ~scl_sync_q & scl_hist_q;
  assign start_c    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_c     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

  assign shift_in_c = {shift_q[DATA_WIDTH-2:0], sda_sync_q};
  assign tx_byte_c  = tx_valid ? tx_data : {DATA_WIDTH{1'b1}};
  assign bit_inc_c  = (bit_cnt_q < ACK_DONE) ? bit_cnt_q + 4'd1 : bit_cnt_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    sda_out_d     = sda_out_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_load_d     = 1'b0;
    tx_underrun_d = 1'b0;
    addressed_d   = addressed_q;
    busy_d        = busy_q;

    if (start_c) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      shift_d     = '0;
      sda_out_d   = 1'b1;
      addressed_d = 1'b0;
      busy_d      = 1'b1;
    end else if (stop_c) begin
      state_d     = IDLE;
      sda_out_d   = 1'b1;
      addressed_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise_c) begin
            shift_d   = shift_in_c;
            bit_cnt_d = bit_inc_c;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = (shift_in_c[DATA_WIDTH-1 -: ADDR_WIDTH] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_inc_c;
          end else if (scl_fall_c) begin
            if (bit_cnt_q == ACK_SLOT) begin
              sda_out_d = 1'b0;
            end else if (bit_cnt_q == ACK_DONE) begin
              addressed_d = 1'b1;
              bit_cnt_d   = '0;
              // shift_q[0] still holds the R/W bit
              if (shift_q[0]) begin
                shift_d       = tx_byte_c;
                sda_out_d     = tx_byte_c[DATA_WIDTH-1];
                tx_load_d     = 1'b1;
                tx_underrun_d = ~tx_valid;
                state_d       = TX_DATA;
              end else begin
                shift_d   = '0;
                sda_out_d = 1'b1;
                state_d   = RX_DATA;
              end
            end
          end
        end
        RX_DATA: begin
          if (scl_rise_c) begin
            shift_d   = shift_in_c;
            bit_cnt_d = bit_inc_c;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d  = shift_in_c;
              rx_valid_d = 1'b1;
              state_d    = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_inc_c;
          end else if (scl_fall_c) begin
            if (bit_cnt_q == ACK_SLOT) begin
              sda_out_d = ~rx_ack_en;
            end else if (bit_cnt_q == ACK_DONE) begin
              bit_cnt_d = '0;
              shift_d   = '0;
              sda_out_d = 1'b1;
              if (!sda_out_q) begin
                state_d = RX_DATA;
              end else begin
                state_d     = WAIT_STOP;
                addressed_d = 1'b0;
              end
            end
          end
        end
        TX_DATA: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_inc_c;
          end else if (scl_fall_c) begin
            if (bit_cnt_q == ACK_SLOT) begin
              sda_out_d = 1'b1;
              state_d   = TX_ACKCHK;
            end else begin
              shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
              sda_out_d = shift_q[DATA_WIDTH-2];
            end
          end
        end
        TX_ACKCHK: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_inc_c;
            if (sda_sync_q) begin
              state_d     = WAIT_STOP;
              addressed_d = 1'b0;
            end
          end else if (scl_fall_c && bit_cnt_q == ACK_DONE) begin
            bit_cnt_d     = '0;
            shift_d       = tx_byte_c;
            sda_out_d     = tx_byte_c[DATA_WIDTH-1];
            tx_load_d     = 1'b1;
            tx_underrun_d = ~tx_valid;
            state_d       = TX_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q    <= 1'b1;
      scl_sync_q    <= 1'b1;
      scl_hist_q    <= 1'b1;
      sda_meta_q    <= 1'b1;
      sda_sync_q    <= 1'b1;
      sda_hist_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      sda_out_q     <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_load_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
      addressed_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      scl_meta_q    <= SCL_in;
      scl_sync_q    <= scl_meta_q;
      scl_hist_q    <= scl_sync_q;
      sda_meta_q    <= SDA_in;
      sda_sync_q    <= sda_meta_q;
      sda_hist_q    <= sda_sync_q;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      sda_out_q     <= sda_out_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_load_q     <= tx_load_d;
      tx_underrun_q <= tx_underrun_d;
      addressed_q   <= addressed_d;
      busy_q        <= busy_d;
    end
  end

  assign SDA_out     = sda_out_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_load     = tx_load_q;
  assign tx_underrun = tx_underrun_q;
  assign addressed   = addressed_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master on a wired-AND SDA bus.
module tb_i2c_target;

  localparam int unsigned Q = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_out;
  logic       sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack_en = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b1;
  logic       tx_load;
  logic       tx_underrun;
  logic       addressed;
  logic       busy;

  always #5 clk = ~clk;

  assign sda_bus = m_sda & sda_out;

  i2c_target dut (
    .clk(clk), .rst(rst), .SCL_in(m_scl), .SDA_in(sda_bus), .SDA_out(sda_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack_en(rx_ack_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_load(tx_load),
    .tx_underrun(tx_underrun), .addressed(addressed), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse counters and a watch on SDA_out changing while SCL is high
  int   rxv_cnt = 0, txl_cnt = 0, und_cnt = 0, low_cnt = 0, viol_cnt = 0;
  logic sda_prev = 1'b1;
  always @(posedge clk) begin
    if (rx_valid === 1'b1) rxv_cnt++;
    if (tx_load === 1'b1) txl_cnt++;
    if (tx_underrun === 1'b1) und_cnt++;
    if (sda_out === 1'b0) low_cnt++;
    if (!rst && sda_out !== sda_prev && m_scl) viol_cnt++;
    sda_prev = sda_out;
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic send_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq(); wq();
  endtask

  task automatic clk_bit(input logic b, output logic s, output logic drv);
    m_sda = b; wq();
    m_scl = 1'b1; wq();
    s = sda_bus;
    drv = sda_out;
    wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack, output logic drv9);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s, drv9);
    clk_bit(1'b1, s, drv9);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s, d;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s, d);
      b[i] = s;
    end
    clk_bit(~mack, s, d);
  endtask

  initial begin
    logic       ack, drv;
    logic       s, d;
    logic [7:0] rb;
    int         rxv0, txl0, und0, low0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sda_out", 32'(sda_out), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_addressed", 32'(addressed), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Write 0x84 then 0xA5, both ACKed
    rxv0 = rxv_cnt;
    send_start();
    check("w_busy", 32'(busy), 32'h1);
    write_byte(8'h84, ack, drv);
    check("w_addr_ack", 32'(ack), 32'h1);
    check("w_addr_drv", 32'(drv), 32'h0);
    check("w_addressed", 32'(addressed), 32'h1);
    write_byte(8'hA5, ack, drv);
    check("w_data_drv", 32'(drv), 32'h0);
    check("w_rxv_cnt", 32'(rxv_cnt - rxv0), 32'h1);
    check("w_rx_data", 32'(rx_data), 32'hA5);
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1;
    repeat (2) @(negedge clk);
    check("stop_busy_2clk", 32'(busy), 32'h1);
    @(negedge clk);
    check("stop_busy_3clk", 32'(busy), 32'h0);
    check("stop_addressed", 32'(addressed), 32'h0);
    wq();

    // Wrong address 0x43 W
    rxv0 = rxv_cnt; low0 = low_cnt;
    send_start();
    write_byte(8'h86, ack, drv);
    check("miss_ack", 32'(ack), 32'h0);
    check("miss_addressed", 32'(addressed), 32'h0);
    write_byte(8'hA5, ack, drv);
    send_stop();
    check("miss_sda_low", 32'(low_cnt - low0), 32'h0);
    check("miss_rxv", 32'(rxv_cnt - rxv0), 32'h0);

    // Read two bytes: 0x3C (ACK), 0xF0 (NACK)
    txl0 = txl_cnt; und0 = und_cnt;
    tx_data = 8'h3C; tx_valid = 1'b1;
    send_start();
    write_byte(8'h85, ack, drv);
    check("r_addr_ack", 32'(ack), 32'h1);
    check("r_load1", 32'(txl_cnt - txl0), 32'h1);
    tx_data = 8'hF0;
    read_byte(1'b1, rb);
    check("r_byte1", 32'(rb), 32'h3C);
    read_byte(1'b0, rb);
    check("r_byte2", 32'(rb), 32'hF0);
    check("r_load2", 32'(txl_cnt - txl0), 32'h2);
    check("r_nack_addressed", 32'(addressed), 32'h0);
    check("r_nack_busy", 32'(busy), 32'h1);
    check("r_nack_sda", 32'(sda_out), 32'h1);
    check("r_no_underrun", 32'(und_cnt - und0), 32'h0);
    send_stop();

    // Read with tx_valid low -> 0xFF and one underrun pulse
    und0 = und_cnt;
    tx_valid = 1'b0;
    send_start();
    write_byte(8'h85, ack, drv);
    read_byte(1'b0, rb);
    check("und_byte", 32'(rb), 32'hFF);
    check("und_cnt", 32'(und_cnt - und0), 32'h1);
    send_stop();
    tx_valid = 1'b1;

    // rx_ack_en = 0: NACK, ignore until repeated START
    rxv0 = rxv_cnt;
    rx_ack_en = 1'b0;
    send_start();
    write_byte(8'h84, ack, drv);
    check("nk_addr_ack", 32'(ack), 32'h1);
    write_byte(8'h11, ack, drv);
    check("nk_data_ack", 32'(ack), 32'h0);
    check("nk_rx_data", 32'(rx_data), 32'h11);
    check("nk_addressed", 32'(addressed), 32'h0);
    write_byte(8'h22, ack, drv);
    check("nk_ignored_ack", 32'(ack), 32'h0);
    check("nk_rxv1", 32'(rxv_cnt - rxv0), 32'h1);
    rx_ack_en = 1'b1;
    send_start();
    write_byte(8'h84, ack, drv);
    write_byte(8'h33, ack, drv);
    check("nk_re_ack", 32'(ack), 32'h1);
    check("nk_rxv2", 32'(rxv_cnt - rxv0), 32'h2);
    check("nk_rx_data2", 32'(rx_data), 32'h33);
    send_stop();

    // Repeated START after 4 data bits
    rxv0 = rxv_cnt;
    send_start();
    write_byte(8'h84, ack, drv);
    clk_bit(1'b1, s, d); clk_bit(1'b0, s, d); clk_bit(1'b1, s, d); clk_bit(1'b0, s, d);
    send_start();
    check("rs_addressed_clr", 32'(addressed), 32'h0);
    write_byte(8'h84, ack, drv);
    check("rs_addr_ack", 32'(ack), 32'h1);
    write_byte(8'h5A, ack, drv);
    check("rs_rxv", 32'(rxv_cnt - rxv0), 32'h1);
    check("rs_rx_data", 32'(rx_data), 32'h5A);
    send_stop();

    // Reset mid-byte, then a clean transfer
    send_start();
    write_byte(8'h84, ack, drv);
    clk_bit(1'b0, s, d); clk_bit(1'b1, s, d); clk_bit(1'b1, s, d);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_sda_out", 32'(sda_out), 32'h1);
    check("mrst_addressed", 32'(addressed), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_rx_data", 32'(rx_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wq();
    send_start();
    write_byte(8'h84, ack, drv);
    check("mrst_addr_ack", 32'(ack), 32'h1);
    write_byte(8'hA7, ack, drv);
    check("mrst_rx_data2", 32'(rx_data), 32'hA7);
    send_stop();
    check("mrst_busy_end", 32'(busy), 32'h0);

    check("sda_change_scl_high", 32'(viol_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
